// File: rtl/serial_command_processor.sv
// Serial command processor: parses LENGTH/COMMAND packets from a UART byte stream
// and serves INFO, memory UPLOAD/DOWNLOAD and system-reset requests.
module serial_command_processor #(
    parameter int FORCE_RST_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  RX,
    input  logic        RX_ready,
    output logic [7:0]  TX,
    output logic        start_TX,
    input  logic        TX_ready,
    output logic        writeToMemory,
    output logic        readFromMemory,
    output logic [31:0] memoryAddress,
    output logic [31:0] memoryWordOut,
    input  logic [31:0] memoryWordIn,
    output logic        force_rst
);
    localparam int RST_CNT_W = (FORCE_RST_CYCLES > 1) ? $clog2(FORCE_RST_CYCLES) : 1;
    localparam logic [RST_CNT_W-1:0] RST_CNT_LAST = RST_CNT_W'(FORCE_RST_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, GET_LEN, GET_CMD, GET_START, GET_END, UP_WORD,
        DN_READ, DN_WAIT, DN_SAMPLE, TX_SEND, TX_WAIT_LOW, TX_WAIT_HIGH, RST_HOLD
    } state_t;

    state_t               state_reg;
    logic [1:0]           byte_cnt_reg;
    logic [23:0]          shift_reg;
    logic [31:0]          addr_reg;
    logic [31:0]          end_reg;
    logic [31:0]          word_reg;
    logic                 upload_reg;
    logic                 info_reg;
    logic [2:0]           tx_idx_reg;
    logic [RST_CNT_W-1:0] rst_cnt_reg;

    logic [31:0] rx_word;
    logic [31:0] next_addr;
    logic        rx_state;
    logic        word_done;
    logic        addr_done;
    logic        tx_last;
    logic [7:0]  tx_byte;

    // The LENGTH field is never needed, so it simply passes through shift_reg.
    assign rx_word   = {shift_reg, RX};
    assign next_addr = addr_reg + 32'd4;
    // A wrap past 0xFFFFFFFC ends the transfer just like reaching END.
    assign addr_done = (next_addr < addr_reg) || (next_addr >= end_reg);
    assign rx_state  = (state_reg == IDLE) || (state_reg == GET_LEN) || (state_reg == GET_CMD) ||
                       (state_reg == GET_START) || (state_reg == GET_END) || (state_reg == UP_WORD);
    assign word_done = rx_state && RX_ready && (byte_cnt_reg == 2'd3);
    assign tx_last   = info_reg ? (tx_idx_reg == 3'd6) : (tx_idx_reg == 3'd3);

    always_comb begin
        tx_byte = 8'h00;
        if (info_reg) begin
            case (tx_idx_reg)
                3'd0:    tx_byte = 8'h53;
                3'd1:    tx_byte = 8'h43;
                3'd2:    tx_byte = 8'h50;
                3'd3:    tx_byte = 8'h20;
                3'd4:    tx_byte = 8'h76;
                3'd5:    tx_byte = 8'h31;
                3'd6:    tx_byte = 8'h0A;
                default: tx_byte = 8'h00;
            endcase
        end else begin
            case (tx_idx_reg[1:0])
                2'd0:    tx_byte = word_reg[31:24];
                2'd1:    tx_byte = word_reg[23:16];
                2'd2:    tx_byte = word_reg[15:8];
                default: tx_byte = word_reg[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            byte_cnt_reg   <= 2'd0;
            shift_reg      <= 24'd0;
            addr_reg       <= 32'd0;
            end_reg        <= 32'd0;
            word_reg       <= 32'd0;
            upload_reg     <= 1'b0;
            info_reg       <= 1'b0;
            tx_idx_reg     <= 3'd0;
            rst_cnt_reg    <= '0;
            TX             <= 8'd0;
            start_TX       <= 1'b0;
            writeToMemory  <= 1'b0;
            readFromMemory <= 1'b0;
            memoryAddress  <= 32'd0;
            memoryWordOut  <= 32'd0;
            force_rst      <= 1'b0;
        end else begin
            start_TX       <= 1'b0;
            writeToMemory  <= 1'b0;
            readFromMemory <= 1'b0;
            if (rx_state && RX_ready) begin
                shift_reg    <= rx_word[23:0];
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
            case (state_reg)
                IDLE: if (RX_ready) state_reg <= GET_LEN;
                GET_LEN: if (word_done) state_reg <= GET_CMD;
                GET_CMD: if (word_done) begin
                    tx_idx_reg <= 3'd0;
                    upload_reg <= (rx_word == 32'd2);
                    case (rx_word)
                        32'd1: begin
                            info_reg  <= 1'b1;
                            state_reg <= TX_SEND;
                        end
                        32'd2, 32'd3: state_reg <= GET_START;
                        32'd4: begin
                            force_rst   <= 1'b1;
                            rst_cnt_reg <= '0;
                            state_reg   <= RST_HOLD;
                        end
                        default: state_reg <= IDLE;
                    endcase
                end
                GET_START: if (word_done) begin
                    addr_reg  <= rx_word;
                    state_reg <= GET_END;
                end
                GET_END: if (word_done) begin
                    end_reg <= rx_word;
                    if (addr_reg >= rx_word) begin
                        state_reg <= IDLE;
                    end else if (upload_reg) begin
                        state_reg <= UP_WORD;
                    end else begin
                        info_reg  <= 1'b0;
                        state_reg <= DN_READ;
                    end
                end
                UP_WORD: if (word_done) begin
                    writeToMemory <= 1'b1;
                    memoryAddress <= addr_reg;
                    memoryWordOut <= rx_word;
                    addr_reg      <= next_addr;
                    if (addr_done) state_reg <= IDLE;
                end
                DN_READ: begin
                    memoryAddress  <= addr_reg;
                    readFromMemory <= 1'b1;
                    state_reg      <= DN_WAIT;
                end
                // One spare cycle covers the synchronous RAM read latency.
                DN_WAIT: state_reg <= DN_SAMPLE;
                DN_SAMPLE: begin
                    word_reg   <= memoryWordIn;
                    tx_idx_reg <= 3'd0;
                    state_reg  <= TX_SEND;
                end
                TX_SEND: if (TX_ready) begin
                    TX        <= tx_byte;
                    start_TX  <= 1'b1;
                    state_reg <= TX_WAIT_LOW;
                end
                TX_WAIT_LOW: if (!TX_ready) state_reg <= TX_WAIT_HIGH;
                TX_WAIT_HIGH: if (TX_ready) begin
                    if (!tx_last) begin
                        tx_idx_reg <= tx_idx_reg + 3'd1;
                        state_reg  <= TX_SEND;
                    end else if (info_reg || addr_done) begin
                        state_reg <= IDLE;
                    end else begin
                        addr_reg  <= next_addr;
                        state_reg <= DN_READ;
                    end
                end
                RST_HOLD: begin
                    rst_cnt_reg <= rst_cnt_reg + RST_CNT_W'(1);
                    if (rst_cnt_reg == RST_CNT_LAST) begin
                        force_rst <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_command_processor.sv
// Directed bench for serial_command_processor: packet table plus reset-during-download sequence.
module tb_serial_command_processor;
    localparam int RST_CYCLES = 16;
    localparam int WAIT_LIMIT = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  RX = 8'd0;
    logic        RX_ready = 1'b0;
    logic [7:0]  TX;
    logic        start_TX;
    logic        TX_ready = 1'b1;
    logic        writeToMemory;
    logic        readFromMemory;
    logic [31:0] memoryAddress;
    logic [31:0] memoryWordOut;
    logic [31:0] memoryWordIn;
    logic        force_rst;

    serial_command_processor #(.FORCE_RST_CYCLES(RST_CYCLES)) dut (
        .clk(clk), .rst(rst), .RX(RX), .RX_ready(RX_ready), .TX(TX), .start_TX(start_TX),
        .TX_ready(TX_ready), .writeToMemory(writeToMemory), .readFromMemory(readFromMemory),
        .memoryAddress(memoryAddress), .memoryWordOut(memoryWordOut),
        .memoryWordIn(memoryWordIn), .force_rst(force_rst)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model: one-cycle read latency.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (writeToMemory) mem[memoryAddress[11:2]] <= memoryWordOut;
        if (readFromMemory) memoryWordIn <= mem[memoryAddress[11:2]];
    end

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] start_a;
        logic [31:0] end_a;
        int          n_wr;
        int          n_rd;
        int          n_tx;
        int          n_rst;
    } vec_t;

    vec_t        vecs [12];
    vec_t        info_vec;
    logic [31:0] exp_mem [logic [31:0]];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] rd_addr_q [$];
    logic [7:0]  tx_q [$];
    int          rst_high_cycles;
    int          overlap_cnt;
    int          tx_violations;
    int          n_checks = 0;
    int          n_fail = 0;

    // Monitor plus transmitter model: TX_ready drops for 50 time units per byte.
    initial begin
        int busy;
        busy = 0;
        forever begin
            @(negedge clk);
            if (writeToMemory === 1'b1) begin
                wr_addr_q.push_back(memoryAddress);
                wr_data_q.push_back(memoryWordOut);
            end
            if (readFromMemory === 1'b1) rd_addr_q.push_back(memoryAddress);
            if (writeToMemory === 1'b1 && readFromMemory === 1'b1) overlap_cnt++;
            if (force_rst === 1'b1) rst_high_cycles++;
            if (start_TX === 1'b1) begin
                if (TX_ready !== 1'b1) tx_violations++;
                tx_q.push_back(TX);
                TX_ready = 1'b0;
                busy = 5;
            end else if (busy > 0) begin
                busy--;
                if (busy == 0) TX_ready = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        RX = b;
        RX_ready = 1'b1;
        @(negedge clk);
        RX_ready = 1'b0;
        RX = 8'd0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    function automatic logic [7:0] exp_tx(input logic [31:0] cmd, input logic [31:0] start_a, input int k);
        logic [55:0] s;
        logic [31:0] a;
        logic [31:0] w;
        s = 56'h53_43_50_20_76_31_0A;
        if (cmd == 32'd1) return s[55 - 8*k -: 8];
        a = start_a + 32'(4 * (k / 4));
        w = exp_mem.exists(a) ? exp_mem[a] : 32'hDEAD_BEEF;
        return w[31 - 8*(k % 4) -: 8];
    endfunction

    task automatic clear_monitors();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        tx_q.delete();
        rst_high_cycles = 0;
        overlap_cnt = 0;
        tx_violations = 0;
    endtask

    task automatic send_header(input vec_t v);
        send_word(32'd0);
        send_word(v.cmd);
        if (v.cmd == 32'd2 || v.cmd == 32'd3) begin
            send_word(v.start_a);
            send_word(v.end_a);
        end
    endtask

    task automatic run_case(input int idx, input vec_t v);
        int cyc;
        clear_monitors();
        send_header(v);
        if (v.cmd == 32'd2) begin
            for (int i = 0; i < v.n_wr; i++) begin
                send_word(32'(i));
                exp_mem[v.start_a + 32'(4 * i)] = 32'(i);
            end
        end
        cyc = 0;
        while (cyc < WAIT_LIMIT && !(wr_addr_q.size() >= v.n_wr && rd_addr_q.size() >= v.n_rd &&
               tx_q.size() >= v.n_tx && rst_high_cycles >= v.n_rst && force_rst === 1'b0 &&
               TX_ready === 1'b1)) begin
            @(negedge clk);
            cyc++;
        end
        check("completion_wait", 32'(cyc < WAIT_LIMIT), 32'd1);
        repeat (40) @(negedge clk);
        check("write_count", 32'(wr_addr_q.size()), 32'(v.n_wr));
        for (int i = 0; i < wr_addr_q.size() && i < v.n_wr; i++) begin
            check("write_addr", wr_addr_q[i], v.start_a + 32'(4 * i));
            check("write_data", wr_data_q[i], 32'(i));
        end
        check("read_count", 32'(rd_addr_q.size()), 32'(v.n_rd));
        for (int i = 0; i < rd_addr_q.size() && i < v.n_rd; i++)
            check("read_addr", rd_addr_q[i], v.start_a + 32'(4 * i));
        check("tx_count", 32'(tx_q.size()), 32'(v.n_tx));
        for (int k = 0; k < tx_q.size() && k < v.n_tx; k++)
            check("tx_byte", 32'(tx_q[k]), 32'(exp_tx(v.cmd, v.start_a, k)));
        check("force_rst_cycles", 32'(rst_high_cycles), 32'(v.n_rst));
        check("strobe_overlap", 32'(overlap_cnt), 32'd0);
        check("tx_handshake", 32'(tx_violations), 32'd0);
        $display("case %0d: cmd=%0d start=0x%08h end=0x%08h writes=%0d reads=%0d tx_bytes=%0d force_rst_cycles=%0d",
                 idx, v.cmd, v.start_a, v.end_a, wr_addr_q.size(), rd_addr_q.size(), tx_q.size(), rst_high_cycles);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_TX"}, 32'(TX), 32'd0);
        check({tag, "_start_TX"}, 32'(start_TX), 32'd0);
        check({tag, "_write"}, 32'(writeToMemory), 32'd0);
        check({tag, "_read"}, 32'(readFromMemory), 32'd0);
        check({tag, "_addr"}, memoryAddress, 32'd0);
        check({tag, "_wdata"}, memoryWordOut, 32'd0);
        check({tag, "_force_rst"}, 32'(force_rst), 32'd0);
    endtask

    initial begin
        int cyc;
        //           cmd     start          end            wr rd  tx  rst
        vecs[0]  = '{32'd1, 32'h0,         32'h0,         0, 0,  7,  0};
        vecs[1]  = '{32'd2, 32'h400,       32'h420,       8, 0,  0,  0};
        vecs[2]  = '{32'd3, 32'h400,       32'h420,       0, 8,  32, 0};
        vecs[3]  = '{32'd2, 32'h400,       32'h400,       0, 0,  0,  0};
        vecs[4]  = '{32'd1, 32'h0,         32'h0,         0, 0,  7,  0};
        vecs[5]  = '{32'd4, 32'h0,         32'h0,         0, 0,  0,  RST_CYCLES};
        vecs[6]  = '{32'd9, 32'h0,         32'h0,         0, 0,  0,  0};
        vecs[7]  = '{32'd1, 32'h0,         32'h0,         0, 0,  7,  0};
        vecs[8]  = '{32'd0, 32'h0,         32'h0,         0, 0,  0,  0};
        vecs[9]  = '{32'd3, 32'h410,       32'h408,       0, 0,  0,  0};
        vecs[10] = '{32'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 2, 0,  0,  0};
        vecs[11] = '{32'd1, 32'h0,         32'h0,         0, 0,  7,  0};
        info_vec = vecs[0];

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 12; i++) run_case(i, vecs[i]);

        // Reset in the middle of a DOWNLOAD must abort it at once.
        clear_monitors();
        send_header(vecs[2]);
        cyc = 0;
        while (cyc < WAIT_LIMIT && tx_q.size() < 2) begin
            @(negedge clk);
            cyc++;
        end
        check("download_progress_wait", 32'(cyc < WAIT_LIMIT), 32'd1);
        #2 rst = 1'b1;
        #1 check_outputs_zero("midrst");
        $display("mid-download reset applied after %0d tx bytes", tx_q.size());
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_case(12, info_vec);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_command_processor.md
Name: serial_command_processor

Overview:
- Byte-stream command interpreter between a UART (RX/TX byte handshakes) and a 32-bit word memory port.
- Parses fixed-format packets, then does one of four things: replies with an ASCII info string, uploads words into memory, downloads words back out over serial, or requests a system reset.
- Sits between the RS232 block and main memory of the FPGA computer.

Parameters:
- FORCE_RST_CYCLES, 16: number of cycles force_rst is held high after a reset command.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- RX  in  8  received byte; valid when RX_ready=1.
- RX_ready  in  1  one-cycle strobe: new byte on RX.
- TX  out  8  byte to transmit.
- start_TX  out  1  one-cycle strobe: transmit TX.
- TX_ready  in  1  transmitter idle.
- writeToMemory  out  1  one-cycle memory write strobe.
- readFromMemory  out  1  one-cycle memory read strobe.
- memoryAddress  out  32  byte address, word aligned.
- memoryWordOut  out  32  write data to memory.
- memoryWordIn  in  32  read data from memory.
- force_rst  out  1  system reset request.

Behaviour:
- Reset: all outputs 0, state IDLE, byte counter 0, all internal registers cleared. Reset mid-operation aborts any transfer immediately.
- All multi-byte fields are 32-bit big-endian (MSB first). A byte is consumed in the cycle RX_ready=1.
- Packet format: LENGTH(4 bytes, latched but ignored), then COMMAND(4 bytes), then arguments.
- Parse states: GET_LEN, then GET_CMD, then dispatch on COMMAND.
- Command 1, INFO: transmit ASCII "SCP v1\n" (7 bytes: 53 43 50 20 76 31 0A), then IDLE.
- Command 2, UPLOAD:
  - Receive START(4 bytes) and END(4 bytes).
  - For addr = START; addr < END; addr += 4: receive a 4-byte word, then pulse writeToMemory for 1 cycle, with memoryAddress=addr and memoryWordOut=word stable during the pulse.
  - The write occurs the cycle after the 4th byte.
  - When addr >= END, go to IDLE. If START >= END, no words are expected and the block returns to IDLE right after END.
- Command 3, DOWNLOAD:
  - Receive START and END.
  - For each addr < END: drive memoryAddress=addr and pulse readFromMemory 1 cycle.
  - Sample memoryWordIn on the 2nd rising edge after the pulse (one-cycle synchronous RAM latency).
  - Transmit the word as 4 bytes, MSB first. Then addr += 4.
  - IDLE after the last word. START >= END sends nothing.
- Command 4, RESET: hold force_rst=1 for FORCE_RST_CYCLES cycles, then IDLE.
- Any other COMMAND (including 0): ignored, return to IDLE, nothing transmitted.
- TX handshake, per byte:
  - Wait until TX_ready=1.
  - Drive TX and pulse start_TX for exactly one cycle. TX is held until the next byte.
  - Wait for TX_ready=0, then TX_ready=1, before the next byte.
  - start_TX is never asserted while TX_ready=0.
- RX bytes arriving while transmitting (INFO/DOWNLOAD) or while force_rst is active are discarded.
- Address arithmetic is 32-bit unsigned; addr+4 wrapping past 0xFFFFFFFC terminates the loop (treated as >= END).
- writeToMemory and readFromMemory are never high in the same cycle.
- The block is IDLE again after every packet; the next byte starts a new LENGTH.

Test Plan:
- INFO packet (00 00 00 00 | 00 00 00 01) with TX_ready dropping 50 time units per byte -> start_TX pulses 7 times, TX = "SCP v1\n" in order, then IDLE.
- UPLOAD packet: len 0, cmd 2, START 0x00000400, END 0x00000420, then words 0..7 as 00 00 00 n -> 8 writeToMemory pulses at 0x400, 0x404 … 0x41C with data 0..7.
- DOWNLOAD packet: cmd 3, START 0x400, END 0x420, memory model returning the uploaded data -> 8 readFromMemory pulses, 32 TX bytes 00 00 00 00, 00 00 00 01 … 00 00 00 07.
- UPLOAD with START=END=0x400 -> no writes; the following INFO packet is answered normally.
- RESET command (cmd 4) -> force_rst high exactly 16 cycles. Unknown cmd 9 -> no TX, no memory strobes, next packet is parsed correctly.
- Assert rst during a DOWNLOAD -> all outputs 0 immediately; a fresh INFO packet afterwards works.
